// File: rtl/bconv_engine.sv
// Binary (+1/-1) convolution engine: streams matrices from SRAM, convolves them with a
// KSIZE x KSIZE kernel and writes packed sign rows. Optional feature macro: BCONV_THRESH_EN.
module bconv_engine #(
  parameter int                KSIZE    = 3,
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter logic [DATA_W-1:0] END_WORD = DATA_W'(16'h00FF)
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int KK = KSIZE * KSIZE;
  localparam int NW = (KK + 15) / 16;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int IW = $clog2(DATA_W);
  localparam int PW = $clog2(KK + 1);

  localparam logic [DATA_W-1:0] COLS_MAX = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] K_WORD   = DATA_W'(KSIZE);
  localparam logic [DATA_W-1:0] K_LAST   = DATA_W'(KSIZE - 1);
  localparam logic [CW-1:0]     K_COLS   = CW'(KSIZE);
  localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(NW);
`ifdef BCONV_THRESH_EN
  localparam logic [ADDR_W-1:0] W_FIRST  = '0;
`else
  localparam logic [ADDR_W-1:0] W_FIRST  = ADDR_W'(1);
  localparam logic [PW-1:0]     MAJORITY = PW'((KK + 1) / 2);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_DIMS, S_FILL, S_CONV, S_WRITE, S_SHIFT, S_DONE
  } state_t;

  state_t            state;
  logic              phase;     // 0: address presented, 1: read data valid
  logic              dim_step;  // 0: ncols word, 1: nrows word
  logic [KK-1:0]     kern;
  logic [DATA_W-1:0] rows [KSIZE];
  logic [CW-1:0]     ncols;
  logic [DATA_W-1:0] nrows;
  logic [DATA_W-1:0] rows_read;
  logic [DATA_W-1:0] out_row;
  logic [IW-1:0]     conv_cnt;
  logic [IW-1:0]     ow;
  logic [IW-1:0]     pc_col;
  logic [PW-1:0]     pc_q;
  logic              pc_vld;
  logic [PW-1:0]     win_mism;
  logic [DATA_W-1:0] shifted;
  logic              pix_bit;
  logic [DATA_W-1:0] rd_word;
  logic              unused_wmem;
`ifdef BCONV_THRESH_EN
  logic [7:0]        thresh;
`endif

  assign rd_word     = sram_dut_read_data;
  assign ow          = IW'(ncols - K_COLS + CW'(1));
  assign unused_wmem = ^wmem_dut_read_data;

  // NOTE: every variable gets a default before the loops, so no latch is inferred.
  always_comb begin
    win_mism = '0;
    shifted  = '0;
    for (int r = 0; r < KSIZE; r++) begin
      shifted = rows[r] >> conv_cnt;
      for (int c = 0; c < KSIZE; c++)
        win_mism = win_mism + PW'(shifted[c] ^ kern[r*KSIZE + c]);
    end
  end

`ifdef BCONV_THRESH_EN
  assign pix_bit = (8'(pc_q) < thresh);
`else
  assign pix_bit = (pc_q < MAJORITY);
`endif

  // NOTE: all state below is sequential and uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                  <= S_IDLE;
      phase                  <= 1'b0;
      dim_step               <= 1'b0;
      dut_busy               <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_wmem_read_address  <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      // NOTE: the row buffer and kernel are a few flops, so they are cleared like any register.
      for (int i = 0; i < KSIZE; i++) rows[i] <= '0;
      kern      <= '0;
      ncols     <= '0;
      nrows     <= '0;
      rows_read <= '0;
      out_row   <= '0;
      conv_cnt  <= '0;
      pc_col    <= '0;
      pc_q      <= '0;
      pc_vld    <= 1'b0;
`ifdef BCONV_THRESH_EN
      thresh    <= '0;
`endif
    end else begin
      // Second pipeline stage: compare the registered popcount, drop the bit into its column.
      pc_vld <= 1'b0;
      if (pc_vld) out_row[pc_col] <= pix_bit;

      case (state)
        S_IDLE: begin
          if (dut_run) begin
            state                  <= S_WLOAD;
            dut_busy               <= 1'b1;
            phase                  <= 1'b0;
            dim_step               <= 1'b0;
            dut_sram_read_address  <= '0;
            dut_sram_write_address <= '0;
            dut_wmem_read_address  <= W_FIRST;
          end
        end

        S_WLOAD: begin
          phase <= ~phase;
          if (phase) begin
`ifdef BCONV_THRESH_EN
            if (dut_wmem_read_address == '0) thresh <= wmem_dut_read_data[15:8];
`endif
            for (int b = 0; b < KK; b++)
              if (dut_wmem_read_address == ADDR_W'(b / 16 + 1))
                kern[b] <= wmem_dut_read_data[b % 16];
            if (dut_wmem_read_address == W_LAST) state <= S_DIMS;
            else dut_wmem_read_address <= dut_wmem_read_address + ADDR_W'(1);
          end
        end

        S_DIMS: begin
          phase <= ~phase;
          if (phase) begin
            dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1);
            if (!dim_step) begin
              if (rd_word == END_WORD) begin
                state <= S_DONE;
              end else begin
                ncols    <= (rd_word > COLS_MAX) ? CW'(DATA_W) : rd_word[CW-1:0];
                dim_step <= 1'b1;
              end
            end else begin
              nrows    <= rd_word;
              dim_step <= 1'b0;
              if (ncols < K_COLS || rd_word < K_WORD) begin
                // Too small for one window: skip its row words and read the next header.
                dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1) + ADDR_W'(rd_word);
              end else begin
                state     <= S_FILL;
                rows_read <= '0;
              end
            end
          end
        end

        S_FILL: begin
          phase <= ~phase;
          if (phase) begin
            dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1);
            for (int i = 0; i < KSIZE - 1; i++) rows[i] <= rows[i+1];
            rows[KSIZE-1] <= rd_word;
            rows_read     <= rows_read + DATA_W'(1);
            if (rows_read == K_LAST) begin
              state    <= S_CONV;
              conv_cnt <= '0;
              out_row  <= '0;
            end
          end
        end

        S_CONV: begin
          // OW select cycles, then two drain cycles while the pipeline empties.
          if (conv_cnt < ow) begin
            pc_q   <= win_mism;
            pc_col <= conv_cnt;
            pc_vld <= 1'b1;
          end
          conv_cnt <= conv_cnt + IW'(1);
          if (conv_cnt == ow + IW'(1)) begin
            state                 <= S_WRITE;
            dut_sram_write_enable <= 1'b1;
            dut_sram_write_data   <= out_row;
          end
        end

        S_WRITE: begin
          dut_sram_write_enable  <= 1'b0;
          dut_sram_write_address <= dut_sram_write_address + ADDR_W'(1);
          phase                  <= 1'b0;
          state                  <= S_SHIFT;
        end

        S_SHIFT: begin
          if (rows_read == nrows) begin
            state    <= S_DIMS;
            phase    <= 1'b0;
            dim_step <= 1'b0;
          end else begin
            phase <= ~phase;
            if (phase) begin
              dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1);
              for (int i = 0; i < KSIZE - 1; i++) rows[i] <= rows[i+1];
              rows[KSIZE-1] <= rd_word;
              rows_read     <= rows_read + DATA_W'(1);
              state         <= S_CONV;
              conv_cnt      <= '0;
              out_row       <= '0;
            end
          end
        end

        S_DONE: begin
          dut_busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bconv_engine.sv
// Scoreboard bench for bconv_engine: a KSIZE=3 and a KSIZE=5 instance, each with its own
// memories, checked against a direct arithmetic model of the convolution rules.
module tb_bconv_engine;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk     = 1'b0;
  logic reset_b = 1'b1;
  logic run3    = 1'b0;
  logic run5    = 1'b0;
  logic busy3, busy5, we3, we5;
  logic [AW-1:0] sra3, wra3, wa3, sra5, wra5, wa5;
  logic [DW-1:0] srd3, wrd3, wd3, srd5, wrd5, wd5;

  logic [15:0] sram3 [0:4095];
  logic [15:0] wmem3 [0:7];
  logic [15:0] sram5 [0:4095];
  logic [15:0] wmem5 [0:7];

  logic [15:0] img_q[$];
  logic [27:0] exp3_q[$];
  logic [27:0] exp5_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   wr_cnt5 = 0;
  logic we3_prev = 1'b0;
  logic we5_prev = 1'b0;

  always #5 clk = ~clk;

  bconv_engine #(.KSIZE(3)) u3 (
    .clk(clk), .reset_b(reset_b), .dut_run(run3), .dut_busy(busy3),
    .dut_sram_read_address(sra3), .sram_dut_read_data(srd3),
    .dut_wmem_read_address(wra3), .wmem_dut_read_data(wrd3),
    .dut_sram_write_address(wa3), .dut_sram_write_data(wd3),
    .dut_sram_write_enable(we3)
  );

  bconv_engine #(.KSIZE(5)) u5 (
    .clk(clk), .reset_b(reset_b), .dut_run(run5), .dut_busy(busy5),
    .dut_sram_read_address(sra5), .sram_dut_read_data(srd5),
    .dut_wmem_read_address(wra5), .wmem_dut_read_data(wrd5),
    .dut_sram_write_address(wa5), .dut_sram_write_data(wd5),
    .dut_sram_write_enable(we5)
  );

  // Synchronous memories: data valid one cycle after the address.
  always @(posedge clk) begin
    srd3 <= sram3[sra3];
    wrd3 <= wmem3[wra3[2:0]];
    srd5 <= sram5[sra5];
    wrd5 <= wmem5[wra5[2:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected {addr,data} per write strobe.
  always @(negedge clk) begin
    logic [27:0] e;
    if (we3) begin
      check("k3 strobe width", {31'b0, we3_prev}, 32'd0);
      if (exp3_q.size() == 0) check("k3 unexpected write", {4'b0, wa3, wd3}, 32'hFFFF_FFFF);
      else begin
        e = exp3_q.pop_front();
        check("k3 write addr", 32'(wa3), 32'(e[27:16]));
        check("k3 write data", 32'(wd3), 32'(e[15:0]));
      end
    end
    if (we5) begin
      wr_cnt5++;
      check("k5 strobe width", {31'b0, we5_prev}, 32'd0);
      if (exp5_q.size() == 0) check("k5 unexpected write", {4'b0, wa5, wd5}, 32'hFFFF_FFFF);
      else begin
        e = exp5_q.pop_front();
        check("k5 write addr", 32'(wa5), 32'(e[27:16]));
        check("k5 write data", 32'(wd5), 32'(e[15:0]));
      end
    end
    we3_prev = we3;
    we5_prev = we5;
  end

  // Reference: parse the matrix stream and evaluate every window by counting mismatches.
  task automatic model(input int k, input logic [24:0] kern, input int thr);
    int p, oaddr, nc, nr, mism;
    logic [15:0] word, rw;
    p = 0;
    oaddr = 0;
    while (img_q[p] != 16'h00FF) begin
      nc = int'(img_q[p]);
      nr = int'(img_q[p+1]);
      p += 2;
      if (nc > 16) nc = 16;
      if (nc >= k && nr >= k) begin
        for (int i = 0; i <= nr - k; i++) begin
          word = '0;
          for (int j = 0; j <= nc - k; j++) begin
            mism = 0;
            for (int r = 0; r < k; r++) begin
              rw = img_q[p+i+r];
              for (int c = 0; c < k; c++)
                if (rw[j+c] != kern[r*k+c]) mism++;
            end
            if (mism < thr) word[j] = 1'b1;
          end
          if (k == 3) exp3_q.push_back({oaddr[11:0], word});
          else        exp5_q.push_back({oaddr[11:0], word});
          oaddr++;
        end
      end
      p += nr;
    end
  endtask

  task automatic add_matrix(input int nc, input int nr, input bit rnd, input logic [15:0] val);
    img_q.push_back(16'(nc));
    img_q.push_back(16'(nr));
    for (int i = 0; i < nr; i++) img_q.push_back(rnd ? 16'($urandom) : val);
  endtask

  task automatic prepare(input int k, input logic [24:0] kern, input logic [7:0] tbyte);
    int thr;
    for (int i = 0; i < img_q.size(); i++)
      if (k == 3) sram3[i] = img_q[i]; else sram5[i] = img_q[i];
    if (k == 3) begin
      wmem3[0] = {tbyte, 8'($urandom)};
      wmem3[1] = kern[15:0];
      wmem3[2] = {7'($urandom), kern[24:16]};
    end else begin
      wmem5[0] = {tbyte, 8'($urandom)};
      wmem5[1] = kern[15:0];
      wmem5[2] = {7'($urandom), kern[24:16]};
    end
`ifdef BCONV_THRESH_EN
    thr = int'(tbyte);
`else
    thr = (k * k + 1) / 2;
`endif
    model(k, kern, thr);
  endtask

  function automatic logic busy_of(input int k);
    return (k == 3) ? busy3 : busy5;
  endfunction

  task automatic set_run(input int k, input logic v);
    if (k == 3) run3 = v; else run5 = v;
  endtask

  task automatic run_and_wait(input int k, input bit rerun, output int busy_cyc);
    int n;
    @(negedge clk);
    set_run(k, 1'b1);
    @(negedge clk);
    set_run(k, 1'b0);
    check($sformatf("k%0d busy rise", k), 32'(busy_of(k)), 32'd1);
    n = 0;
    while (busy_of(k) && n < 3000) begin
      @(negedge clk);
      n++;
      if (rerun && n == 8) set_run(k, 1'b1);
      if (rerun && n == 9) set_run(k, 1'b0);
    end
    check($sformatf("k%0d busy fall", k), 32'(busy_of(k)), 32'd0);
    busy_cyc = n;
    repeat (3) @(negedge clk);
    check($sformatf("k%0d pending writes", k),
          32'((k == 3) ? exp3_q.size() : exp5_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy3"}, 32'(busy3), 32'd0);
    check({tag, " we3"}, 32'(we3), 32'd0);
    check({tag, " raddr3"}, 32'(sra3), 32'd0);
    check({tag, " waddr3"}, 32'(wa3), 32'd0);
    check({tag, " wdata3"}, 32'(wd3), 32'd0);
    check({tag, " wmaddr3"}, 32'(wra3), 32'd0);
    check({tag, " busy5"}, 32'(busy5), 32'd0);
    check({tag, " we5"}, 32'(we5), 32'd0);
    check({tag, " raddr5"}, 32'(sra5), 32'd0);
    check({tag, " waddr5"}, 32'(wa5), 32'd0);
    check({tag, " wdata5"}, 32'(wd5), 32'd0);
    check({tag, " wmaddr5"}, 32'(wra5), 32'd0);
  endtask

  initial begin
    int bc, n, start;
    #2 reset_b = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk);
    reset_b = 1'b1;

    // 4x4 all ones, kernel all ones then all zeros.
    img_q.delete();
    add_matrix(4, 4, 1'b0, 16'h000F);
    img_q.push_back(16'h00FF);
    prepare(3, {16'($urandom), 9'h1FF}, 8'd5);
    run_and_wait(3, 1'b0, bc);
    prepare(3, {16'($urandom), 9'h000}, 8'd5);
    run_and_wait(3, 1'b0, bc);

    // Empty runs: busy pulse bounded by WLOAD + 4.
    img_q.delete();
    img_q.push_back(16'h00FF);
    prepare(3, 25'($urandom), 8'd5);
    run_and_wait(3, 1'b0, bc);
    check("k3 empty busy bound", 32'(bc <= 2 + 4), 32'd1);
    prepare(5, 25'($urandom), 8'd13);
    run_and_wait(5, 1'b0, bc);
    check("k5 empty busy bound", 32'(bc <= 4 + 4), 32'd1);

    // Degenerate matrix followed by a 3x3 checkerboard.
    img_q.delete();
    add_matrix(2, 5, 1'b1, 16'h0000);
    img_q.push_back(16'd3);
    img_q.push_back(16'd3);
    img_q.push_back(16'h0005);
    img_q.push_back(16'h0002);
    img_q.push_back(16'h0005);
    img_q.push_back(16'h00FF);
    prepare(3, {16'($urandom), 9'h155}, 8'd5);
    run_and_wait(3, 1'b0, bc);

    // Random streams, including clamped widths, degenerate shapes and a run pulse while busy.
    for (int t = 0; t < 4; t++) begin
      img_q.delete();
      for (int m = 0; m < 3; m++)
        add_matrix($urandom_range(1, 20), $urandom_range(1, 7), 1'b1, 16'h0000);
      img_q.push_back(16'h00FF);
      prepare(3, 25'($urandom), 8'd5);
      run_and_wait(3, t == 1, bc);
    end

    img_q.delete();
    add_matrix(16, 16, 1'b1, 16'h0000);
    add_matrix(7, 6, 1'b1, 16'h0000);
    img_q.push_back(16'h00FF);
    prepare(5, 25'($urandom), 8'd13);
    run_and_wait(5, 1'b0, bc);

`ifdef BCONV_THRESH_EN
    img_q.delete();
    img_q.push_back(16'd3);
    img_q.push_back(16'd3);
    img_q.push_back(16'h0007);
    img_q.push_back(16'h0007);
    img_q.push_back(16'h0006);
    img_q.push_back(16'h00FF);
    prepare(3, {16'($urandom), 9'h1FF}, 8'd1);
    run_and_wait(3, 1'b0, bc);
    prepare(3, {16'($urandom), 9'h1FF}, 8'd2);
    run_and_wait(3, 1'b0, bc);
`endif

    // Abort a 16x16 KSIZE=5 run in the middle of its third row.
    img_q.delete();
    add_matrix(16, 16, 1'b1, 16'h0000);
    img_q.push_back(16'h00FF);
    prepare(5, 25'($urandom), 8'd13);
    start = wr_cnt5;
    @(negedge clk);
    run5 = 1'b1;
    @(negedge clk);
    run5 = 1'b0;
    n = 0;
    while (wr_cnt5 < start + 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("k5 writes before abort", 32'(wr_cnt5 - start), 32'd2);
    repeat (6) @(negedge clk);
    reset_b = 1'b0;
    exp5_q.delete();
    #1 check_idle_outputs("abort");
    repeat (4) @(negedge clk);
    check("abort busy5 held", 32'(busy5), 32'd0);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);

    // Recovery after abort: addresses restart at 0.
    img_q.delete();
    add_matrix(6, 5, 1'b1, 16'h0000);
    img_q.push_back(16'h00FF);
    prepare(5, 25'($urandom), 8'd13);
    run_and_wait(5, 1'b0, bc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
